syscall_controller: RTL and testbench
=====================================

// Module: syscall_controller
// PURPOSE
//   Sequences SYSCALL instructions flagged by the decode stage. Stalls fetch/decode and
//   bubbles execute until older instructions have written back, so $v0/$a0 reads are
//   current. Then hands funct/param1 to the host/testbench over a valid/ready handshake.
//   Releases the pipeline afterwards, or halts it permanently on exit.
// PARAMETERS
//   DRAIN_CYCLES  3   cycles to wait for E/M/W to retire before sampling operands (>=1)
//   FUNCT_EXIT    10  syscall_funct value meaning program exit (halt after handshake)
//   CNT_W         16  width of completed-syscall counter
// PORTS
//   clock           in   1      system clock, all state on rising edge
//   reset           in   1      synchronous, active-high
//   syscall_D       in   1      decode stage holds a SYSCALL this cycle
//   syscall_funct   in   32     $v0 value from decode register read
//   syscall_param1  in   32     $a0 value from decode register read
//   stall           out  1      hold PC and F/D pipeline register
//   flush_E         out  1      load bubble into D/E register
//   host_valid      out  1      syscall request pending to host
//   host_funct      out  32     latched funct, stable while host_valid
//   host_param      out  32     latched param1, stable while host_valid
//   host_ready      in   1      host accepts request
//   halted          out  1      exit syscall completed; pipeline frozen
//   syscall_count   out  CNT_W  completed syscalls, wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, host_valid=0, host_funct=0, host_param=0, halted=0,
//     syscall_count=0. Reset is honoured in every state, including REQ and HALT.
//     A request pending at reset is dropped.
//   Derived outputs (combinational):
//     stall = (IDLE & syscall_D) | DRAIN | REQ | HALT
//     flush_E = stall
//     host_valid = REQ
//   IDLE: if syscall_D, load cnt=DRAIN_CYCLES and go to DRAIN. stall asserts that same cycle.
//   DRAIN: cnt decrements each cycle. When cnt==1, latch syscall_funct/syscall_param1
//     into host_funct/host_param and go to REQ. DRAIN therefore lasts DRAIN_CYCLES cycles.
//   REQ: outputs held. A transfer occurs on a cycle with host_valid & host_ready.
//     host_ready may already be high on entry; the transfer then happens in the first REQ cycle.
//     On transfer, syscall_count++. Go to HALT if host_funct==FUNCT_EXIT, else RELEASE.
//     Exactly one transfer per SYSCALL.
//   RELEASE: stall=0 for exactly one cycle; the SYSCALL advances out of decode.
//     syscall_D is ignored this cycle (it still reflects the old instruction). Go to IDLE.
//   HALT: halted=1, stall=1, flush_E=1 until reset. syscall_D is ignored.
//   Latency: syscall_D seen at T gives host_valid first at T+DRAIN_CYCLES+1.
//     Minimum stall is DRAIN_CYCLES+2 cycles.
//     Back-to-back SYSCALLs: the second is seen in IDLE the cycle after RELEASE.
//   Unknown funct values are passed to the host unchanged; no decoding is done here.
// TESTING
//   1. Reset; syscall_D=1 at T, funct=1, param=42, host_ready=1
//      -> host_valid only at T+4 with 1/42; stall high T..T+4, low at T+5; count=1.
//   2. host_ready low for 5 REQ cycles, then high
//      -> host_valid, host_funct, host_param stable throughout; single transfer; count+1.
//   3. syscall_funct changes from 0 to 1 during DRAIN (late writeback)
//      -> host_funct=1, the value at the last DRAIN cycle.
//   4. funct=10 handshake -> halted=1 and stall=1 forever; further syscall_D ignored;
//      reset returns to IDLE with all outputs 0.
//   5. Two SYSCALLs back-to-back (syscall_D high across RELEASE)
//      -> exactly two transfers, one RELEASE cycle between them, count=2.
//   6. Reset asserted mid-DRAIN and mid-REQ -> next cycle IDLE, host_valid=0, no transfer.

Source files
------------

// File: rtl/syscall_controller.sv
// syscall_controller: drains the pipeline on a decoded SYSCALL, hands funct/param to the host, then releases or halts.
module syscall_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int FUNCT_EXIT   = 10,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             syscall_D,
  input  logic [31:0]      syscall_funct,
  input  logic [31:0]      syscall_param1,
  output logic             stall,
  output logic             flush_E,
  output logic             host_valid,
  output logic [31:0]      host_funct,
  output logic [31:0]      host_param,
  input  logic             host_ready,
  output logic             halted,
  output logic [CNT_W-1:0] syscall_count
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, DRAIN, REQ, RELEASE, HALT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] funct_q, funct_d, param_q, param_d;
  logic [CNT_W-1:0] count_q, count_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    funct_d = funct_q;
    param_d = param_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (syscall_D) begin
        state_d = DRAIN;
        cnt_d = CW'(DRAIN_CYCLES);
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        // operands sampled on the last drain cycle so late writebacks are seen
        if (cnt_q == CW'(1)) begin
          funct_d = syscall_funct;
          param_d = syscall_param1;
          state_d = REQ;
        end
      end
      REQ: if (host_ready) begin
        count_d = count_q + CNT_W'(1);
        state_d = (funct_q == 32'(FUNCT_EXIT)) ? HALT : RELEASE;
      end
      RELEASE: state_d = IDLE;
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      funct_q <= '0;
      param_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      funct_q <= funct_d;
      param_q <= param_d;
      count_q <= count_d;
    end
  end
  assign stall = (state_q == IDLE && syscall_D) || state_q == DRAIN || state_q == REQ || state_q == HALT;
  assign flush_E = stall;
  assign host_valid = state_q == REQ;
  assign halted = state_q == HALT;
  assign host_funct = funct_q;
  assign host_param = param_q;
  assign syscall_count = count_q;
endmodule

// File: tb/tb_syscall_controller.sv
// tb_syscall_controller: directed scenarios plus randomized run against a timeline reference model.
module tb_syscall_controller;
  localparam int D = 3;
  localparam logic [31:0] EXIT = 32'd10;
  logic clock = 1'b0;
  logic reset, syscall_D, host_ready, stall, flush_E, host_valid, halted;
  logic [31:0] syscall_funct, syscall_param1, host_funct, host_param;
  logic [15:0] syscall_count;
  int checks = 0;
  int failures = 0;

  syscall_controller #(.DRAIN_CYCLES(D), .FUNCT_EXIT(10), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .syscall_D(syscall_D), .syscall_funct(syscall_funct),
    .syscall_param1(syscall_param1), .stall(stall), .flush_E(flush_E), .host_valid(host_valid),
    .host_funct(host_funct), .host_param(host_param), .host_ready(host_ready), .halted(halted),
    .syscall_count(syscall_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    syscall_D = 1'b0;
    host_ready = 1'b0;
    syscall_funct = '0;
    syscall_param1 = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({stall, flush_E, host_valid, halted} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {stall, flush_E, host_valid, halted});
    end
    checks++;
    if (host_funct !== 32'd0 || host_param !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h exp=0/0", host_funct, host_param);
    end
    checks++;
    if (syscall_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", syscall_count);
    end
  endtask

  task automatic test_basic();
    syscall_D = 1'b1;
    syscall_funct = 32'd1;
    syscall_param1 = 32'd42;
    host_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (host_valid !== (k == 4)) begin
        failures++;
        $display("FAIL basic_valid k=%0d got=%b exp=%b", k, host_valid, (k == 4));
      end
      checks++;
      if (stall !== (k <= 4) || flush_E !== (k <= 4)) begin
        failures++;
        $display("FAIL basic_stall k=%0d got=%b/%b exp=%b", k, stall, flush_E, (k <= 4));
      end
      if (k == 4) begin
        checks++;
        if (host_funct !== 32'd1 || host_param !== 32'd42) begin
          failures++;
          $display("FAIL basic_data got=%0d/%0d exp=1/42", host_funct, host_param);
        end
      end
      if (k == 5) syscall_D = 1'b0;
      tick();
    end
    checks++;
    if (syscall_count !== 16'd1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL basic_count got=%0d stall=%b exp=1 stall=0", syscall_count, stall);
    end
  endtask

  task automatic test_backpressure();
    syscall_D = 1'b1;
    syscall_funct = 32'd7;
    syscall_param1 = 32'h1234;
    host_ready = 1'b0;
    #1;
    repeat (4) tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (host_valid !== 1'b1 || host_funct !== 32'd7 || host_param !== 32'h1234) begin
        failures++;
        $display("FAIL bp_hold k=%0d got=%b %h %h exp=1 7 1234", k, host_valid, host_funct, host_param);
      end
      syscall_funct = $urandom;
      syscall_param1 = $urandom;
      tick();
    end
    host_ready = 1'b1;
    #1;
    checks++;
    if (host_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_valid got=%b exp=1", host_valid);
    end
    tick();
    checks++;
    if (host_valid !== 1'b0 || stall !== 1'b0 || syscall_count !== 16'd2) begin
      failures++;
      $display("FAIL bp_release got=%b %b %0d exp=0 0 2", host_valid, stall, syscall_count);
    end
    host_ready = 1'b0;
    syscall_D = 1'b0;
    tick();
    tick();
    checks++;
    if (syscall_count !== 16'd2 || host_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_single got=%0d %b exp=2 0", syscall_count, host_valid);
    end
  endtask

  task automatic test_late_writeback();
    syscall_D = 1'b1;
    syscall_funct = 32'd0;
    syscall_param1 = 32'd0;
    host_ready = 1'b0;
    #1;
    tick();
    tick();
    syscall_funct = 32'd1;
    tick();
    syscall_param1 = 32'd99;
    tick();
    syscall_funct = 32'd2;
    syscall_param1 = 32'd5;
    host_ready = 1'b1;
    #1;
    checks++;
    if (host_valid !== 1'b1 || host_funct !== 32'd1 || host_param !== 32'd99) begin
      failures++;
      $display("FAIL late_wb got=%b %0d %0d exp=1 1 99", host_valid, host_funct, host_param);
    end
    tick();
    syscall_D = 1'b0;
    host_ready = 1'b0;
    tick();
    checks++;
    if (syscall_count !== 16'd3) begin
      failures++;
      $display("FAIL late_count got=%0d exp=3", syscall_count);
    end
  endtask

  task automatic test_exit();
    syscall_D = 1'b1;
    syscall_funct = EXIT;
    syscall_param1 = 32'd3;
    host_ready = 1'b1;
    #1;
    repeat (5) tick();
    for (int k = 0; k < 10; k++) begin
      syscall_D = 1'($urandom % 2);
      host_ready = 1'($urandom % 2);
      #1;
      checks++;
      if (halted !== 1'b1 || stall !== 1'b1 || flush_E !== 1'b1 || host_valid !== 1'b0) begin
        failures++;
        $display("FAIL exit_hold k=%0d got=%b%b%b%b exp=1110", k, halted, stall, flush_E, host_valid);
      end
      tick();
    end
    checks++;
    if (syscall_count !== 16'd4) begin
      failures++;
      $display("FAIL exit_count got=%0d exp=4", syscall_count);
    end
    do_reset();
    checks++;
    if ({halted, stall, flush_E, host_valid} !== 4'b0000 || syscall_count !== 16'd0 || host_funct !== 32'd0) begin
      failures++;
      $display("FAIL exit_reset got=%b%b%b%b %0d %h exp=0000 0 0", halted, stall, flush_E, host_valid, syscall_count, host_funct);
    end
  endtask

  task automatic test_back_to_back();
    int xfers = 0;
    int rels = 0;
    do_reset();
    syscall_D = 1'b1;
    host_ready = 1'b1;
    syscall_funct = 32'd5;
    syscall_param1 = 32'd6;
    #1;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (host_valid !== (k == 4 || k == 10)) begin
        failures++;
        $display("FAIL b2b_valid k=%0d got=%b", k, host_valid);
      end
      checks++;
      if (stall !== !(k == 5 || k == 11)) begin
        failures++;
        $display("FAIL b2b_stall k=%0d got=%b", k, stall);
      end
      if (host_valid && host_ready) xfers++;
      if (!stall) rels++;
      if (k == 11) syscall_D = 1'b0;
      tick();
    end
    checks++;
    if (xfers != 2 || rels != 2 || syscall_count !== 16'd2) begin
      failures++;
      $display("FAIL b2b_total got=%0d %0d %0d exp=2 2 2", xfers, rels, syscall_count);
    end
  endtask

  task automatic test_reset_mid();
    syscall_D = 1'b1;
    syscall_funct = 32'd11;
    syscall_param1 = 32'd12;
    host_ready = 1'b0;
    #1;
    repeat (2) tick();
    reset = 1'b1;
    syscall_D = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (host_valid !== 1'b0 || stall !== 1'b0 || syscall_count !== 16'd0) begin
      failures++;
      $display("FAIL rst_drain got=%b %b %0d exp=0 0 0", host_valid, stall, syscall_count);
    end
    repeat (6) begin
      checks++;
      if (host_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_drain_idle got=%b exp=0", host_valid);
      end
      tick();
    end
    syscall_D = 1'b1;
    #1;
    repeat (4) tick();
    checks++;
    if (host_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_req_pre got=%b exp=1", host_valid);
    end
    host_ready = 1'b1;
    reset = 1'b1;
    syscall_D = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (host_valid !== 1'b0 || stall !== 1'b0 || syscall_count !== 16'd0 || host_funct !== 32'd0) begin
      failures++;
      $display("FAIL rst_req got=%b %b %0d %h exp=0 0 0 0", host_valid, stall, syscall_count, host_funct);
    end
    host_ready = 1'b0;
  endtask

  task automatic test_random();
    logic m_halt = 1'b0;
    logic m_rel = 1'b0;
    int m_start = -1;
    int hc = 0;
    logic [31:0] m_funct = '0;
    logic [31:0] m_param = '0;
    logic [15:0] m_count = '0;
    logic e_stall, e_hv, e_halt;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom % 150 == 0) || hc > 4;
      syscall_D = ($urandom % 3 == 0);
      host_ready = 1'($urandom % 2);
      syscall_funct = ($urandom % 12 == 0) ? EXIT : 32'($urandom % 16);
      syscall_param1 = $urandom;
      #1;
      if (m_halt) begin
        e_stall = 1'b1; e_hv = 1'b0; e_halt = 1'b1;
      end else if (m_start < 0) begin
        e_stall = syscall_D; e_hv = 1'b0; e_halt = 1'b0;
      end else if (m_rel) begin
        e_stall = 1'b0; e_hv = 1'b0; e_halt = 1'b0;
      end else begin
        e_stall = 1'b1; e_hv = (n - m_start > D); e_halt = 1'b0;
      end
      checks++;
      if (stall !== e_stall || flush_E !== e_stall) begin
        failures++;
        $display("FAIL rnd_stall n=%0d got=%b/%b exp=%b", n, stall, flush_E, e_stall);
      end
      checks++;
      if (host_valid !== e_hv || halted !== e_halt) begin
        failures++;
        $display("FAIL rnd_valid n=%0d got=%b/%b exp=%b/%b", n, host_valid, halted, e_hv, e_halt);
      end
      checks++;
      if (host_funct !== m_funct || host_param !== m_param || syscall_count !== m_count) begin
        failures++;
        $display("FAIL rnd_data n=%0d got=%h %h %0d exp=%h %h %0d", n, host_funct, host_param, syscall_count, m_funct, m_param, m_count);
      end
      if (reset) begin
        m_halt = 1'b0; m_rel = 1'b0; m_start = -1; m_funct = '0; m_param = '0; m_count = '0;
      end else if (m_halt) begin
      end else if (m_start < 0) begin
        if (syscall_D) m_start = n;
      end else if (m_rel) begin
        m_rel = 1'b0; m_start = -1;
      end else if (n - m_start == D) begin
        m_funct = syscall_funct; m_param = syscall_param1;
      end else if (n - m_start > D && host_ready) begin
        m_count++;
        if (m_funct == EXIT) begin
          m_halt = 1'b1; m_start = -1;
        end else m_rel = 1'b1;
      end
      hc = m_halt ? hc + 1 : 0;
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_late_writeback();
    test_exit();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
